mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's byte-wide memory port. It serves the CPU's read-address/write-address/write-strobe protocol from an on-chip byte RAM and a small MMIO window at the top of the address space. It also owns the CPU's reset line, holding the CPU in reset while a byte-stream loader (fed by the UART receiver) writes a program image into RAM.

## Interface
- addr_width, 9, byte address width; matches the CPU's addr_width.
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_raddr  in  addr_width  CPU read address.
- mem_waddr  in  addr_width  CPU write address.
- mem_data_in  in  8  CPU write data.
- mem_write  in  1  CPU write strobe, one cycle per byte.
- mem_data_out  out  8  read data to the CPU.
- mem_ready  out  1  high when CPU accesses are being served.
- load_start  in  1  single-cycle pulse that starts a program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  8  program byte.
- load_end  in  1  single-cycle pulse that ends the load.
- cpu_reset  out  1  active-high reset to the CPU.
- cpu_halt  out  1  halt request to the CPU.
- cpu_halted  in  1  CPU halted status.
- leds  out  8  LED register.

## Operation
- **Address map.** RAM occupies 0 .. 2^addr_width-17. MMIO occupies the top 16 bytes; base MB = 2^addr_width-16.
- **MMIO registers.**
  - MB+0..MB+3: 32-bit cycle counter, big-endian.
    - A read of MB+0 returns counter[31:24] and, on the same edge, latches counter[23:0] into a shadow register.
    - Reads of MB+1..MB+3 return the shadow bytes, which gives a coherent 32-bit read sequence.
    - Writes are ignored.
  - MB+4: leds. Readable and writable.
  - MB+5: control.
    - Write: bit0=1 sets cpu_halt, which is sticky. Bit0=0 has no effect.
    - Read: {6'b0, cpu_halted, cpu_halt}.
  - MB+6..MB+15: read 0; writes are ignored.
- **Counter.** Free-running; increments every cycle in every state and wraps 0xFFFFFFFF→0.
- **State machine.** Three states: HOLD, RUN, LOAD.
  - HOLD: cpu_reset=1, mem_ready=0. After 4 cycles → RUN.
  - RUN: cpu_reset=0, mem_ready=1. CPU reads and writes are served.
  - LOAD: cpu_reset=1, mem_ready=0, cpu_halt cleared. CPU writes are ignored.
    - Each load_valid cycle writes load_data to RAM[ptr], then ptr increments.
    - ptr wraps from MB-1 to 0, so the loader never touches MMIO.
  - load_start in any state → LOAD with ptr=0. This includes load_start while already in LOAD, which restarts the pointer.
  - load_end in LOAD → HOLD. load_end in any other state is ignored.
  - load_valid and load_end in the same cycle: the byte is written, then the state changes to HOLD.
  - load_start and load_end in the same cycle: load_start wins.
- **Reads.** Reads are served in every state; the result is undefined to the CPU outside RUN.
- **Reset values** (resetn low, asynchronously): state HOLD with its cycle count at 0, mem_data_out 0, mem_ready 0, cpu_reset 1, cpu_halt 0, leds 0, counter 0, shadow 0, ptr 0. RAM contents are not reset.
- **resetn mid-load:** the load is abandoned and the machine restarts in HOLD.

## Timing
- **Read latency: 1 cycle, registered.**
  - mem_data_out at edge N+1 reflects mem_raddr as sampled at edge N+1. The CPU sets the address at edge N and samples at edge N+2.
  - mem_data_out holds while mem_raddr is stable.
- **Write:** committed on the edge where mem_write=1, using mem_waddr and mem_data_in sampled at that same edge.
- **Same-edge read and write to one address:** the read returns the old data (read-first). The next cycle returns the new data.
- **CPU write and loader write on the same edge:** only possible outside RUN, where CPU writes are dropped, so no conflict exists.
- **cpu_halt:** rises the cycle after the control write edge.
- **leds:** update on the write edge.
- **HOLD→RUN:** mem_ready and the release of cpu_reset change on the same edge, exactly 4 cycles after entering HOLD.

## Test plan
- **Reset:** pulse resetn low mid-cycle → all outputs take their reset values immediately; cpu_reset falls and mem_ready rises on the 4th edge after resetn rises.
- **Load then read:** load_start, then bytes 0x12, 0x34, 0x56 with a gap cycle, then load_end → RUN after 4 HOLD cycles; reads of addresses 0/1/2 return 0x12/0x34/0x56 one cycle after the address is applied.
- **Load pointer wrap:** stream MB+1 bytes (byte k = k mod 256) → address 0 holds the last byte (MB mod 256); MMIO leds remain 0.
- **Write/read hazards:** write 0xA5 to address 7 with a same-edge read of 7 → old value returned, then 0xA5 the next cycle. CPU write during LOAD → RAM unchanged.
- **Counter coherency:** force the counter to 0x00FFFFFE; read MB+0..MB+3 on consecutive cycles → bytes 0x00,0xFF,0xFF,0xFE or a consistent later snapshot, never a torn value.
- **Control register:** write 0x01 to MB+5 → cpu_halt=1; drive cpu_halted=1 → reading MB+5 returns 0x03; load_start → cpu_halt=0.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory port bundle.
//   mem_raddr    - read address, CPU to memory
//   mem_waddr    - write address, CPU to memory
//   mem_data_in  - write data, CPU to memory
//   mem_write    - write strobe, one cycle per byte
//   mem_data_out - registered read data, memory to CPU
//   mem_ready    - memory is serving CPU accesses
// master is the CPU side, slave is the memory side.
`timescale 1ns/1ps

interface mem_responder_if #(
  parameter int addr_width = 9
) ();
  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic [7:0]            mem_data_in;
  logic                  mem_write;
  logic [7:0]            mem_data_out;
  logic                  mem_ready;

  modport master (
    output mem_raddr, mem_waddr, mem_data_in, mem_write,
    input  mem_data_out, mem_ready
  );

  modport slave (
    input  mem_raddr, mem_waddr, mem_data_in, mem_write,
    output mem_data_out, mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU byte port.
// Serves CPU reads/writes from an on-chip byte RAM plus a 16-byte MMIO
// window at the top of the address space, and owns the CPU reset while a
// byte-stream loader writes a program image into RAM.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   mem                  - CPU memory port (slave side)
//   load_start/valid/end - loader control, load_data is the program byte
//   cpu_reset            - active-high reset to the CPU
//   cpu_halt/cpu_halted  - sticky halt request / halted status
//   leds                 - LED register
// MMIO (offset from top-16): 0..3 cycle counter (big-endian, offset 0
// snapshots the low 24 bits), 4 leds, 5 control, 6..15 read as zero.
`timescale 1ns/1ps

module mem_responder #(
  parameter int addr_width = 9
) (
  input  logic           clk,
  input  logic           resetn,
  mem_responder_if.slave mem,
  input  logic           load_start,
  input  logic           load_valid,
  input  logic [7:0]     load_data,
  input  logic           load_end,
  output logic           cpu_reset,
  output logic           cpu_halt,
  input  logic           cpu_halted,
  output logic [7:0]     leds
);

  localparam int RAM_DEPTH = (1 << addr_width) - 16;
  localparam logic [addr_width-1:0] MMIO_BASE = addr_width'(RAM_DEPTH);
  localparam logic [addr_width-1:0] PTR_LAST  = addr_width'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_LOAD} state_t;

  state_t                state;
  logic [1:0]            hold_cnt;
  logic [addr_width-1:0] ptr;
  logic [31:0]           counter;
  logic [23:0]           shadow;
  logic [7:0]            rdata_q;
  logic                  ready_q;
  logic [7:0]            ram [RAM_DEPTH];

  logic                  rd_mmio;
  logic                  wr_mmio;
  logic                  cpu_wr;
  logic                  loader_we;
  logic                  ram_we;
  logic [addr_width-1:0] ram_waddr;
  logic [7:0]            ram_wdata;
  logic [7:0]            rd_next;

  assign mem.mem_data_out = rdata_q;
  assign mem.mem_ready    = ready_q;

  assign rd_mmio = (mem.mem_raddr >= MMIO_BASE);
  assign wr_mmio = (mem.mem_waddr >= MMIO_BASE);

  // CPU writes only land in RUN; outside RUN they are dropped, so the
  // loader and the CPU never compete for the RAM write port.
  assign cpu_wr    = (state == ST_RUN) && mem.mem_write;
  // A restart pulse takes priority over a byte arriving on the same edge.
  assign loader_we = (state == ST_LOAD) && load_valid && !load_start;
  assign ram_we    = loader_we || (cpu_wr && !wr_mmio);
  assign ram_waddr = loader_we ? ptr : mem.mem_waddr;
  assign ram_wdata = loader_we ? load_data : mem.mem_data_in;

  // Read mux; the registered stage below gives the one-cycle latency.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    rd_next = 8'h00;
    if (!rd_mmio) begin
      rd_next = ram[mem.mem_raddr];
    end else begin
      case (mem.mem_raddr[3:0])
        4'd0:    rd_next = counter[31:24];
        4'd1:    rd_next = shadow[23:16];
        4'd2:    rd_next = shadow[15:8];
        4'd3:    rd_next = shadow[7:0];
        4'd4:    rd_next = leds;
        4'd5:    rd_next = {6'b0, cpu_halted, cpu_halt};
        default: rd_next = 8'h00;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; clearing it would need a sequencer
  // and its contents are defined by the loader anyway.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Read data, free-running counter and its coherency shadow. The RAM
  // read above sees pre-edge contents, so a same-edge write is read-first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 8'h00;
      counter <= 32'h0;
      shadow  <= 24'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      rdata_q <= rd_next;
      counter <= counter + 32'd1;
      if (rd_mmio && mem.mem_raddr[3:0] == 4'd0) begin
        shadow <= counter[23:0];
      end
    end
  end

  // Sequencer and MMIO write registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_HOLD;
      hold_cnt  <= 2'd0;
      ptr       <= '0;
      cpu_reset <= 1'b1;
      ready_q   <= 1'b0;
      cpu_halt  <= 1'b0;
      leds      <= 8'h00;
    end else begin
      if (cpu_wr && wr_mmio && mem.mem_waddr[3:0] == 4'd4) begin
        leds <= mem.mem_data_in;
      end
      if (cpu_wr && wr_mmio && mem.mem_waddr[3:0] == 4'd5 && mem.mem_data_in[0]) begin
        cpu_halt <= 1'b1;
      end

      if (load_start) begin
        // Entering (or restarting) a load from any state.
        state     <= ST_LOAD;
        ptr       <= '0;
        hold_cnt  <= 2'd0;
        cpu_reset <= 1'b1;
        ready_q   <= 1'b0;
        cpu_halt  <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            // Fourth edge in HOLD releases the CPU.
            if (hold_cnt == 2'd3) begin
              state     <= ST_RUN;
              cpu_reset <= 1'b0;
              ready_q   <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 2'd1;
            end
          end
          ST_RUN: begin
            state <= ST_RUN;
          end
          ST_LOAD: begin
            if (load_valid) begin
              // Wrap below the MMIO window so the loader never hits it.
              ptr <= (ptr == PTR_LAST) ? '0 : ptr + addr_width'(1);
            end
            if (load_end) begin
              state    <= ST_HOLD;
              hold_cnt <= 2'd0;
            end
          end
          default: begin
            state     <= ST_HOLD;
            hold_cnt  <= 2'd0;
            cpu_reset <= 1'b1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_mem_responder;

  localparam int MB = 496;

  logic       clk = 1'b0;
  logic       resetn;
  logic       load_start, load_valid, load_end;
  logic [7:0] load_data;
  logic       cpu_reset, cpu_halt, cpu_halted;
  logic [7:0] leds;

  int errors = 0;
  int checks = 0;

  // Reference cycle counter: counts rising edges since reset released.
  logic [31:0] model_cnt;

  mem_responder_if #(.addr_width(9)) bus ();

  mem_responder #(.addr_width(9)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem        (bus),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_end   (load_end),
    .cpu_reset  (cpu_reset),
    .cpu_halt   (cpu_halt),
    .cpu_halted (cpu_halted),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_cnt <= 32'h0;
    else         model_cnt <= model_cnt + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers (no comparisons) ----------------

  task automatic do_read(input logic [8:0] a, output logic [7:0] d);
    bus.mem_raddr = a;
    @(negedge clk);
    d = bus.mem_data_out;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    bus.mem_waddr   = a;
    bus.mem_data_in = d;
    bus.mem_write   = 1'b1;
    @(negedge clk);
    bus.mem_write   = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    @(negedge clk);
    load_end = 1'b0;
  endtask

  // Counts falling edges until mem_ready is seen, bounded at 20.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.mem_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    int n;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %b exp 1", cpu_reset); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", bus.mem_ready); end
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b exp 0", cpu_halt); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL rst_leds: got %h exp 00", leds); end
    checks++; if (bus.mem_data_out !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h exp 00", bus.mem_data_out); end
    resetn = 1'b1;
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL rst_hold_cycles: got %0d exp 4", n); end
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rst_release: got %b exp 0", cpu_reset); end
  endtask

  task automatic test_load_read();
    int n;
    logic [7:0] d;
    pulse_start();
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL load_cpu_reset: got %b exp 1", cpu_reset); end
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got %b exp 0", bus.mem_ready); end
    load_byte(8'h12);
    load_byte(8'h34);
    @(negedge clk);
    load_byte(8'h56);
    pulse_end();
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL load_hold_cycles: got %0d exp 4", n); end
    do_read(9'd0, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL load_rd0: got %h exp 12", d); end
    do_read(9'd1, d);
    checks++; if (d !== 8'h34) begin errors++; $display("FAIL load_rd1: got %h exp 34", d); end
    do_read(9'd2, d);
    checks++; if (d !== 8'h56) begin errors++; $display("FAIL load_rd2: got %h exp 56", d); end
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] d;
    pulse_start();
    for (int k = 0; k <= MB; k++) load_byte(8'(k));
    pulse_end();
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL wrap_hold_cycles: got %0d exp 4", n); end
    do_read(9'd0, d);
    checks++; if (d !== 8'hF0) begin errors++; $display("FAIL wrap_rd0: got %h exp f0", d); end
    do_read(9'd1, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL wrap_rd1: got %h exp 01", d); end
    do_read(9'(MB - 1), d);
    checks++; if (d !== 8'hEF) begin errors++; $display("FAIL wrap_rd_last: got %h exp ef", d); end
    do_read(9'(MB + 4), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL wrap_rd_leds: got %h exp 00", d); end
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL wrap_leds: got %h exp 00", leds); end
  endtask

  task automatic test_hazard();
    int n;
    logic [7:0] d;
    cpu_write(9'd7, 8'h3C);
    bus.mem_waddr   = 9'd7;
    bus.mem_data_in = 8'hA5;
    bus.mem_write   = 1'b1;
    bus.mem_raddr   = 9'd7;
    @(negedge clk);
    bus.mem_write   = 1'b0;
    checks++; if (bus.mem_data_out !== 8'h3C) begin errors++; $display("FAIL haz_read_first: got %h exp 3c", bus.mem_data_out); end
    @(negedge clk);
    checks++; if (bus.mem_data_out !== 8'hA5) begin errors++; $display("FAIL haz_read_next: got %h exp a5", bus.mem_data_out); end
    pulse_start();
    cpu_write(9'd7, 8'h5A);
    cpu_write(9'(MB + 4), 8'h66);
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL haz_load_leds: got %h exp 00", leds); end
    pulse_end();
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL haz_hold_cycles: got %0d exp 4", n); end
    do_read(9'd7, d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL haz_load_drop: got %h exp a5", d); end
  endtask

  task automatic test_mmio();
    logic [7:0] d;
    cpu_write(9'(MB + 4), 8'h81);
    checks++; if (leds !== 8'h81) begin errors++; $display("FAIL mmio_leds_port: got %h exp 81", leds); end
    do_read(9'(MB + 4), d);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL mmio_leds_read: got %h exp 81", d); end
    cpu_write(9'(MB + 6), 8'hFF);
    do_read(9'(MB + 6), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mmio_rsvd6: got %h exp 00", d); end
    do_read(9'(MB + 15), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mmio_rsvd15: got %h exp 00", d); end
  endtask

  task automatic test_counter();
    logic [31:0] snap;
    logic [7:0]  d;
    cpu_write(9'(MB), 8'h00);
    for (int r = 0; r < 2; r++) begin
      snap = model_cnt;
      do_read(9'(MB), d);
      checks++; if (d !== snap[31:24]) begin errors++; $display("FAIL cnt_b3: got %h exp %h", d, snap[31:24]); end
      do_read(9'(MB + 1), d);
      checks++; if (d !== snap[23:16]) begin errors++; $display("FAIL cnt_b2: got %h exp %h", d, snap[23:16]); end
      do_read(9'(MB + 2), d);
      checks++; if (d !== snap[15:8]) begin errors++; $display("FAIL cnt_b1: got %h exp %h", d, snap[15:8]); end
      do_read(9'(MB + 3), d);
      checks++; if (d !== snap[7:0]) begin errors++; $display("FAIL cnt_b0: got %h exp %h", d, snap[7:0]); end
      repeat (5) @(negedge clk);
      do_read(9'(MB + 3), d);
      checks++; if (d !== snap[7:0]) begin errors++; $display("FAIL cnt_shadow_hold: got %h exp %h", d, snap[7:0]); end
    end
  endtask

  task automatic test_control();
    int n;
    logic [7:0] d;
    cpu_write(9'(MB + 5), 8'h00);
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL ctl_bit0_zero: got %b exp 0", cpu_halt); end
    cpu_write(9'(MB + 5), 8'h01);
    checks++; if (cpu_halt !== 1'b1) begin errors++; $display("FAIL ctl_halt_set: got %b exp 1", cpu_halt); end
    cpu_halted = 1'b1;
    do_read(9'(MB + 5), d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL ctl_read: got %h exp 03", d); end
    cpu_write(9'(MB + 5), 8'h00);
    checks++; if (cpu_halt !== 1'b1) begin errors++; $display("FAIL ctl_sticky: got %b exp 1", cpu_halt); end
    pulse_start();
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL ctl_load_clear: got %b exp 0", cpu_halt); end
    do_read(9'(MB + 5), d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL ctl_read_load: got %h exp 02", d); end
    cpu_halted = 1'b0;
    pulse_end();
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL ctl_hold_cycles: got %0d exp 4", n); end
  endtask

  task automatic test_load_corners();
    int n;
    logic [7:0] d;
    pulse_end();
    checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL cor_end_in_run: got %b exp 1", bus.mem_ready); end
    pulse_start();
    load_byte(8'h11);
    load_byte(8'h22);
    load_start = 1'b1;
    load_end   = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_end   = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL cor_start_wins_ready: got %b exp 0", bus.mem_ready); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL cor_start_wins_reset: got %b exp 1", cpu_reset); end
    load_byte(8'h77);
    load_valid = 1'b1;
    load_data  = 8'h88;
    load_end   = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_end   = 1'b0;
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL cor_hold_cycles: got %0d exp 4", n); end
    do_read(9'd0, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL cor_rd0: got %h exp 77", d); end
    do_read(9'd1, d);
    checks++; if (d !== 8'h88) begin errors++; $display("FAIL cor_valid_end: got %h exp 88", d); end
    do_read(9'd2, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL cor_rd2: got %h exp 02", d); end
  endtask

  task automatic test_reset_midload();
    int n;
    logic [7:0] d;
    cpu_write(9'(MB + 4), 8'h5A);
    checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL mid_leds_pre: got %h exp 5a", leds); end
    pulse_start();
    load_byte(8'hDE);
    do_read(9'd1, d);
    #2 resetn = 1'b0;
    #1;
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL mid_leds: got %h exp 00", leds); end
    checks++; if (bus.mem_data_out !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %h exp 00", bus.mem_data_out); end
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL mid_cpu_reset: got %b exp 1", cpu_reset); end
    @(negedge clk);
    resetn = 1'b1;
    wait_ready(n);
    checks++; if (n !== 4) begin errors++; $display("FAIL mid_hold_cycles: got %0d exp 4", n); end
    do_read(9'd0, d);
    checks++; if (d !== 8'hDE) begin errors++; $display("FAIL mid_ram_kept: got %h exp de", d); end
  endtask

  initial begin
    resetn          = 1'b0;
    load_start      = 1'b0;
    load_valid      = 1'b0;
    load_end        = 1'b0;
    load_data       = 8'h00;
    cpu_halted      = 1'b0;
    bus.mem_raddr   = '0;
    bus.mem_waddr   = '0;
    bus.mem_data_in = 8'h00;
    bus.mem_write   = 1'b0;

    test_reset();
    test_load_read();
    test_wrap();
    test_hazard();
    test_mmio();
    test_counter();
    test_control();
    test_load_corners();
    test_reset_midload();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
